// File: rtl/fadd_pipe.sv
// fadd_pipe: three-stage pipelined floating-point adder/subtractor with valid/ready flow control
module fadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] src,
  input  logic [W-1:0] sink,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dest,
  output logic         ovf,
  output logic         udf
);
  localparam int SW = MAN_W + 4;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic sa, sb, za, zb, xa, xb, na, nb, swap;
  logic [EXP_W-1:0] ea, eb, d, e1_d;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0] ma, mb, msml;
  logic [W-2:0] ka, kb;
  logic [2*SW-1:0] ext;
  logic [SW-1:0] mb1_d, ms1_d;
  logic [W-1:0] spr1_d;
  int dsh;
  logic v1_q, sp1_q, sg1_q, es1_q, zs1_q;
  logic [W-1:0] spr1_q;
  logic [EXP_W-1:0] e1_q;
  logic [SW-1:0] mb1_q, ms1_q;
  logic v2_q, sp2_q, sg2_q, zs2_q;
  logic [W-1:0] spr2_q;
  logic [EXP_W-1:0] e2_q;
  logic [SW:0] s2_q, s2_d;
  int lz, ne, fe;
  logic zero, rup, rc;
  logic [SW-1:0] norm;
  logic [MAN_W+1:0] rm;
  logic [MAN_W-1:0] frac;
  logic [W-1:0] dest_d, dest_q;
  logic ovf_d, udf_d, ovf_q, udf_q, out_valid_q;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign dest      = dest_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

  assign sa = src[W-1];
  assign sb = sink[W-1] ^ sub;
  assign ea = src[W-2:MAN_W];
  assign eb = sink[W-2:MAN_W];
  assign fa = src[MAN_W-1:0];
  assign fb = sink[MAN_W-1:0];
  assign za = ea == '0;
  assign zb = eb == '0;
  assign xa = &ea;
  assign xb = &eb;
  assign na = xa && fa != '0;
  assign nb = xb && fb != '0;
  assign ma = za ? '0 : {1'b1, fa};
  assign mb = zb ? '0 : {1'b1, fb};
  assign ka = za ? '0 : src[W-2:0];
  assign kb = zb ? '0 : sink[W-2:0];
  assign swap = kb > ka;
  assign spr1_d = (na || nb || (xa && xb && sa != sb)) ? QNAN : xa ? src : {sb, sink[W-2:0]};

  // Stage 1 datapath: pick the larger magnitude and align the smaller one, folding lost bits into sticky
  always_comb begin
    e1_d  = swap ? eb : ea;
    d     = swap ? eb - ea : ea - eb;
    msml  = swap ? ma : mb;
    mb1_d = {swap ? mb : ma, 3'b000};
    dsh   = int'(d) > SW ? SW : int'(d);
    ext   = {msml, 3'b000, {SW{1'b0}}} >> dsh;
    ms1_d = ext[2*SW-1:SW] | {{(SW-1){1'b0}}, |ext[SW-1:0]};
  end

  // Stage 1 register: unpacked, ordered and aligned operands
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q <= 1'b0;
      sp1_q <= 1'b0;
      spr1_q <= '0;
      sg1_q <= 1'b0;
      es1_q <= 1'b0;
      zs1_q <= 1'b0;
      e1_q <= '0;
      mb1_q <= '0;
      ms1_q <= '0;
    end else if (in_ready) begin
      v1_q <= in_valid;
      sp1_q <= xa || xb;
      spr1_q <= spr1_d;
      sg1_q <= swap ? sb : sa;
      es1_q <= sa ^ sb;
      zs1_q <= sa & sb;
      e1_q <= e1_d;
      mb1_q <= mb1_d;
      ms1_q <= ms1_d;
    end
  end

  assign s2_d = es1_q ? {1'b0, mb1_q} - {1'b0, ms1_q} : {1'b0, mb1_q} + {1'b0, ms1_q};

  // Stage 2 register: raw significand sum with carry bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q <= 1'b0;
      sp2_q <= 1'b0;
      spr2_q <= '0;
      sg2_q <= 1'b0;
      zs2_q <= 1'b0;
      e2_q <= '0;
      s2_q <= '0;
    end else if (in_ready) begin
      v2_q <= v1_q;
      sp2_q <= sp1_q;
      spr2_q <= spr1_q;
      sg2_q <= sg1_q;
      zs2_q <= zs1_q;
      e2_q <= e1_q;
      s2_q <= s2_d;
    end
  end

  // Stage 3 datapath: normalise, round to nearest even, then clamp to inf or zero on range exits
  always_comb begin
    lz = SW;
    for (int i = 0; i < SW; i++) if (s2_q[i]) lz = SW - 1 - i;
    zero   = s2_q == '0;
    norm   = s2_q[SW] ? {s2_q[SW:2], s2_q[1] | s2_q[0]} : s2_q[SW-1:0] << lz;
    ne     = s2_q[SW] ? int'(e2_q) + 1 : int'(e2_q) - lz;
    rup    = norm[2] & (norm[1] | norm[0] | norm[3]);
    rm     = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rup);
    rc     = rm[MAN_W+1];
    fe     = ne + int'(rc);
    frac   = rc ? rm[MAN_W:1] : rm[MAN_W-1:0];
    ovf_d  = !sp2_q && !zero && ne > 0 && fe >= EMAX;
    udf_d  = !sp2_q && !zero && ne <= 0;
    dest_d = sp2_q ? spr2_q : zero ? {zs2_q, {(W-1){1'b0}}} : udf_d ? {sg2_q, {(W-1){1'b0}}} :
             ovf_d ? {sg2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sg2_q, fe[EXP_W-1:0], frac};
  end

  // Stage 3 output register: result and flags held while the consumer stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      dest_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (in_ready) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        dest_q <= dest_d;
        ovf_q <= ovf_d;
        udf_q <= udf_d;
      end
    end
  end
endmodule

// File: tb/tb_fadd_pipe.sv
// tb_fadd_pipe: randomized and directed checks of fadd_pipe against an exact-arithmetic single-precision model
module tb_fadd_pipe;
  logic clk = 0, rstn, in_valid, in_ready, sub, out_valid, out_ready, ovf, udf;
  logic [31:0] src, sink, dest;
  int n_cmp = 0, n_bad = 0;
  logic [33:0] q[$];
  logic held_v = 0;
  logic [33:0] held;
  logic [31:0] da[10], db[10];
  logic ds[10];
  logic [33:0] dx[10];

  fadd_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .src(src), .sink(sink),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .dest(dest), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // exact value of each operand as a wide integer, exact sum, then round-to-nearest-even; returns {ovf,udf,dest}
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b0, input logic s);
    logic [31:0] b;
    logic [319:0] ma, mb, mag;
    logic sr, rb, st, an, bn, ai, bi;
    logic [23:0] sig;
    logic [24:0] r;
    int p, e;
    b = {b0[31] ^ s, b0[30:0]};
    an = a[30:23] == 8'hff && a[22:0] != 0;
    bn = b[30:23] == 8'hff && b[22:0] != 0;
    ai = a[30:23] == 8'hff && a[22:0] == 0;
    bi = b[30:23] == 8'hff && b[22:0] == 0;
    if (an || bn || (ai && bi && a[31] != b[31])) return {2'b00, 32'h7fc00000};
    if (ai) return {2'b00, a};
    if (bi) return {2'b00, b};
    ma = a[30:23] == 0 ? 320'd0 : 320'({1'b1, a[22:0]}) << (a[30:23] - 8'd1);
    mb = b[30:23] == 0 ? 320'd0 : 320'({1'b1, b[22:0]}) << (b[30:23] - 8'd1);
    if (a[31] == b[31]) begin mag = ma + mb; sr = a[31]; end
    else if (ma >= mb) begin mag = ma - mb; sr = a[31]; end
    else begin mag = mb - ma; sr = b[31]; end
    if (mag == 0) return {2'b00, a[31] & b[31], 31'd0};
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {2'b01, sr, 31'd0};
    if (p > 23) begin
      sig = 24'(mag >> (p - 23));
      rb = mag[p-24];
      st = |(mag & ((320'd1 << (p - 24)) - 320'd1));
    end else begin
      sig = 24'(mag << (23 - p));
      rb = 0;
      st = 0;
    end
    r = {1'b0, sig} + 25'(rb && (st || sig[0]));
    if (r[24]) begin e++; r = r >> 1; end
    if (e >= 255) return {2'b10, sr, 8'hff, 23'd0};
    return {2'b00, sr, 8'(e), r[22:0]};
  endfunction

  // scoreboard: every negedge checks handshake rule, output order/value, stall stability; records accepted inputs
  always @(negedge clk) if (rstn) begin
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    if (out_valid) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_output: got %h want none", dest);
      end else if (out_ready) chk("result", {ovf, udf, dest}, q.pop_front());
      if (held_v) chk("stall_hold", {ovf, udf, dest}, held);
      held_v = !out_ready;
      held = {ovf, udf, dest};
    end else held_v = 0;
    if (in_valid && in_ready) q.push_back(model(src, sink, sub));
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic ok = 0;
    src = a; sink = b; sub = s; in_valid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL accept_timeout: got in_ready 0 want 1"); end
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] pick_exp();
    int r = $urandom_range(0, 31);
    return r == 0 ? 8'd0 : r == 1 ? 8'd255 : r == 2 ? 8'd254 : r == 3 ? 8'd1 : 8'($urandom_range(1, 254));
  endfunction

  task automatic rand_ops();
    logic [7:0] ea, eb;
    int t;
    ea = pick_exp();
    t = int'(ea) + $urandom_range(0, 6) - 3;
    eb = $urandom_range(0, 1) ? 8'(t < 0 ? 0 : t > 255 ? 255 : t) : pick_exp();
    src = {1'($urandom), ea, 23'($urandom)};
    sink = {1'($urandom), eb, 23'($urandom)};
    if (ea == 8'hff && $urandom_range(0, 1)) src[22:0] = 0;
    if (eb == 8'hff && $urandom_range(0, 1)) sink[22:0] = 0;
    if ($urandom_range(0, 15) == 0) sink = src;
    sub = 1'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int lat;
    da = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h4B800000, 32'h4B800001,
           32'h7F7FFFFF, 32'h00800001, 32'h7F800000, 32'h7F800000, 32'h40400000};
    db = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000,
           32'h7F7FFFFF, 32'h00800000, 32'hFF800000, 32'h3F800000, 32'h3F800000};
    ds = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
    dx = '{{2'b00, 32'h40000000}, {2'b00, 32'h00000000}, {2'b00, 32'h80000000}, {2'b00, 32'h4B800000},
           {2'b00, 32'h4B800002}, {2'b10, 32'h7F800000}, {2'b01, 32'h00000000}, {2'b00, 32'h7FC00000},
           {2'b00, 32'h7F800000}, {2'b00, 32'h40000000}};
    rstn = 0; in_valid = 0; out_ready = 1; sub = 0; src = 0; sink = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dest", dest, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    @(posedge clk); #1 rstn = 1;
    for (int i = 0; i < 10; i++) begin
      chk("model_pin", model(da[i], db[i], ds[i]), dx[i]);
      push(da[i], db[i], ds[i]);
      in_valid = 0;
      if (i == 0) begin
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
          @(negedge clk);
          if (out_valid) lat = k;
        end
        chk("latency", lat, 3);
      end
      repeat (5) @(posedge clk); #1;
    end
    fork
      begin
        push(32'h3F800000, 32'h40000000, 0);
        push(32'h40400000, 32'h3F000000, 1);
        push(32'hC1200000, 32'h41200000, 0);
        push(32'h42C80000, 32'h3DCCCCCD, 0);
        push(32'h3F800000, 32'h33800000, 1);
        in_valid = 0;
      end
      begin
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        @(posedge clk); #1 out_ready = 0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1 out_ready = 1;
      end
    join
    repeat (12) @(posedge clk); #1;
    chk("bp_drain", q.size(), 0);
    push(32'h3F800000, 32'h3F800000, 0);
    push(32'h40000000, 32'h40000000, 0);
    in_valid = 0;
    #2 rstn = 0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    q.delete();
    held_v = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_quiet", out_valid, 0);
    end
    @(posedge clk); #1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = $urandom_range(0, 3) != 0;
      if (!in_valid || acc) begin
        in_valid = $urandom_range(0, 4) != 0;
        rand_ops();
      end
    end
    in_valid = 0;
    out_ready = 1;
    repeat (12) @(posedge clk); #1;
    chk("final_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
